// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised RGB-panel timing generator with a built-in test pattern.
// A single pixel counter pair (h_cnt, v_cnt) walks the whole frame. Every panel-facing
// output is a registered decode of that position, so the outputs trail the counters by
// exactly one clock and all of them change on the same edge.
// Start and stop take effect only at a frame boundary, so the panel never sees a partial frame.
module lcd_timing_gen #(
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int H_ACT      = 800,
    parameter int H_FP       = 40,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 21,
    parameter int V_ACT      = 480,
    parameter int V_FP       = 1,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int DATA_W     = 8,
    parameter int CHECK_LOG2 = 5,
    localparam int XW = $clog2(H_ACT),
    localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            pat_mode,
    input  logic [3*DATA_W-1:0]   solid_rgb,
    output logic                  lcd_hsync,
    output logic                  lcd_vsync,
    output logic                  lcd_de,
    output logic [XW-1:0]         pix_x,
    output logic [YW-1:0]         pix_y,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [3*DATA_W-1:0]   lcd_rgb,
    output logic                  running
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HA      = H_SYNC + H_BP;
    localparam int VA      = V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int CW      = 3 * DATA_W;
    // Working width for pattern arithmetic: wide enough for both the gradient
    // channel and the checker bit, so narrow coordinates get zero-extended.
    localparam int PW      = (DATA_W > CHECK_LOG2 + 1) ? DATA_W : CHECK_LOG2 + 1;

    // Counter-width copies of the timing landmarks keep every compare width-matched.
    localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_SYNC_C = HCW'(H_SYNC);
    localparam logic [HCW-1:0] HA_C    = HCW'(HA);
    localparam logic [HCW-1:0] HE_C    = HCW'(HA + H_ACT);
    localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_SYNC_C = VCW'(V_SYNC);
    localparam logic [VCW-1:0] VA_C    = VCW'(VA);
    localparam logic [VCW-1:0] VE_C    = VCW'(VA + V_ACT);

    // Parameter sanity: a zero-width porch or sync would collapse the decode windows.
    if (H_SYNC < 1 || H_BP < 1 || H_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_FP < 1) begin : g_bad_timing
        $error("lcd_timing_gen: every sync and porch width must be at least 1");
    end
    if (H_ACT < 8) begin : g_bad_hact
        $error("lcd_timing_gen: H_ACT must be at least 8 for the colour bars");
    end
    if (CHECK_LOG2 >= XW) begin : g_bad_check
        $error("lcd_timing_gen: CHECK_LOG2 must be smaller than the column width");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [HCW-1:0]   h_cnt;
    logic [VCW-1:0]   v_cnt;
    logic [1:0]       mode_q;

    logic             hs_act;
    logic             vs_act;
    logic             de_n;
    logic             ls_n;
    logic             fs_n;
    logic [XW-1:0]    x_n;
    logic [YW-1:0]    y_n;
    logic [PW-1:0]    xe;
    logic [PW-1:0]    ye;
    logic [2:0]       bar;
    logic [2:0]       bar_rgb;
    logic             chk;
    logic [DATA_W-1:0] grad_r;
    logic [CW-1:0]    rgb_n;

    // Run/idle control and frame counters; en only matters while idle or at the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            running <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                            if (!en) begin
                                state_q <= ST_IDLE;
                                running <= 1'b0;
                            end
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Pattern selection is captured at counter (0,0) so a frame never mixes two patterns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'd0;
        end else if (h_cnt == '0 && v_cnt == '0) begin
            mode_q <= pat_mode;
        end
    end

    // Position decode: sync windows, active window, strobes and active coordinates.
    always_comb begin
        hs_act = (h_cnt < H_SYNC_C);
        vs_act = (v_cnt < V_SYNC_C);
        de_n   = (h_cnt >= HA_C) && (h_cnt < HE_C) && (v_cnt >= VA_C) && (v_cnt < VE_C);
        ls_n   = (h_cnt == '0);
        fs_n   = (h_cnt == '0) && (v_cnt == '0);
        x_n    = '0;
        y_n    = '0;
        if (de_n) begin
            x_n = XW'(h_cnt - HA_C);
            y_n = YW'(v_cnt - VA_C);
        end
    end

    // Test-pattern colour for the decoded pixel; blanked outside the active window.
    always_comb begin
        xe  = PW'(x_n);
        ye  = PW'(y_n);
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x_n) >= (i * H_ACT) / 8) begin
                bar = 3'(i);
            end
        end
        case (bar)
            3'd0:    bar_rgb = 3'b111;  // white
            3'd1:    bar_rgb = 3'b110;  // yellow
            3'd2:    bar_rgb = 3'b011;  // cyan
            3'd3:    bar_rgb = 3'b010;  // green
            3'd4:    bar_rgb = 3'b101;  // magenta
            3'd5:    bar_rgb = 3'b100;  // red
            3'd6:    bar_rgb = 3'b001;  // blue
            default: bar_rgb = 3'b000;  // black
        endcase
        chk    = xe[CHECK_LOG2] ^ ye[CHECK_LOG2];
        grad_r = xe[DATA_W-1:0];
        case (mode_q)
            2'd0:    rgb_n = solid_rgb;
            2'd1:    rgb_n = {{DATA_W{bar_rgb[2]}}, {DATA_W{bar_rgb[1]}}, {DATA_W{bar_rgb[0]}}};
            2'd2:    rgb_n = {CW{chk}};
            default: rgb_n = {grad_r, ye[DATA_W-1:0], ~grad_r};
        endcase
        if (!de_n) begin
            rgb_n = '0;
        end
    end

    // Output register: one stage behind the counters, inactive whenever idle or in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_hsync   <= ~HS_POL;
            lcd_vsync   <= ~VS_POL;
            lcd_de      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            lcd_rgb     <= '0;
        end else if (state_q == ST_RUN) begin
            lcd_hsync   <= hs_act ? HS_POL : ~HS_POL;
            lcd_vsync   <= vs_act ? VS_POL : ~VS_POL;
            lcd_de      <= de_n;
            pix_x       <= x_n;
            pix_y       <= y_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
            lcd_rgb     <= rgb_n;
        end else begin
            lcd_hsync   <= ~HS_POL;
            lcd_vsync   <= ~VS_POL;
            lcd_de      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            lcd_rgb     <= '0;
        end
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised LCD/RGB-panel timing generator, successor to the fixed 800x480 timing block.
- Produces hsync, vsync, data-enable, 0-based active-pixel coordinates, line/frame start strobes and a built-in test-pattern RGB stream.
- Sits between the pixel clock domain root and the panel pins. Frame-synchronous start/stop is controlled by `en`.

Parameters:
- H_SYNC, 128, hsync pulse width (clocks)
- H_BP, 88, horizontal back porch
- H_ACT, 800, active pixels per line
- H_FP, 40, horizontal front porch
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 21, vertical back porch
- V_ACT, 480, active lines
- V_FP, 1, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- DATA_W, 8, bits per colour channel
- CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2
- Derived: H_TOTAL = sum of H params; V_TOTAL = sum of V params; XW = clog2(H_ACT); YW = clog2(V_ACT)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run request; start/stop only at frame boundary
- pat_mode  in  2  0 solid, 1 colour bars, 2 checker, 3 gradient
- solid_rgb  in  3*DATA_W  colour for mode 0, {r,g,b}
- lcd_hsync  out  1  horizontal sync, polarity HS_POL
- lcd_vsync  out  1  vertical sync, polarity VS_POL
- lcd_de  out  1  active-pixel enable
- pix_x  out  XW  active column, 0..H_ACT-1; 0 when de low
- pix_y  out  YW  active row, 0..V_ACT-1; 0 when de low
- line_start  out  1  1-cycle strobe at h=0 of every line
- frame_start  out  1  1-cycle strobe at h=0, v=0
- lcd_rgb  out  3*DATA_W  pixel data {r,g,b}; 0 when de low
- running  out  1  generator active

Behaviour:
Reset and idle
- On rst (async): h_cnt = 0, v_cnt = 0, running = 0. All outputs go to their inactive values:
  - sync pins at the inactive level (!HS_POL, !VS_POL)
  - de, strobes, pix_x, pix_y, rgb all 0
- Idle (running = 0): counters held at 0; outputs held inactive.

Start and stop
- Start: on the first clk edge with en = 1 while idle, running <= 1. Counters are at (0,0) and advance from the next edge.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt = H_TOTAL-1 and wraps after V_TOTAL-1.
- Stop: en is sampled only at the edge where (h,v) = (H_TOTAL-1, V_TOTAL-1).
  - If en = 0 there, running <= 0 and counters go to 0 (idle).
  - Otherwise the next frame begins seamlessly.
- Deasserting en mid-frame never truncates a frame. Reasserting en before the boundary cancels the stop.

Output latency
- All outputs are registered. Outputs reflect counter position (h,v) exactly 1 cycle after the counters hold (h,v).
- Every output is aligned to the same cycle.

Decode, with HA = H_SYNC+H_BP and VA = V_SYNC+V_BP
- hsync active iff h < H_SYNC.
- vsync active iff v < V_SYNC. Vsync edges coincide with h = 0.
- de iff HA <= h < HA+H_ACT and VA <= v < VA+V_ACT.
- pix_x = h-HA and pix_y = v-VA while de = 1.
- line_start iff h = 0. frame_start iff h = 0 and v = 0.

Test pattern
- pat_mode is latched at frame start (counter (0,0)). A mid-frame change takes effect on the next frame.
- Mode 0 (solid): rgb = solid_rgb (sampled live).
- Mode 1 (colour bars): 8 bars; bar i spans pix_x in [i*H_ACT/8, (i+1)*H_ACT/8), with bounds computed at elaboration.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full channel = all ones.
- Mode 2 (checker): white if pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2], else black.
- Mode 3 (gradient): r = pix_x[DATA_W-1:0], g = pix_y[DATA_W-1:0], b = all ones minus r. Coordinates are zero-extended if narrower than DATA_W.

Elaboration checks
- Every porch and sync parameter >= 1.
- H_ACT >= 8.
- CHECK_LOG2 < XW.

Test Plan:
Small config for scenarios 1-5: H = 2/3/8/2 (H_TOTAL = 15), V = 1/2/4/1 (V_TOTAL = 8), DATA_W = 4, CHECK_LOG2 = 1.
1. Reset, en = 1, pulse rst mid-run -> all outputs immediately go inactive (hsync = 1, vsync = 1, de = 0, rgb = 0). After release, frame_start appears 1 cycle after the start edge, then every 120 cycles.
2. Free run, one frame -> hsync low for 2 of 15 cycles per line; vsync low for 15 cycles starting with frame_start; de high 8 cycles on lines 3..6 only (32 de cycles per frame); pix_x steps 0..7 and pix_y steps 0..3.
3. pat_mode = 1 -> on each active line, rgb over pix_x 0..7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
4. pat_mode = 2 -> row 0 = 000, 000, FFF, FFF, 000, 000, FFF, FFF; row 2 is inverted. Switching pat_mode to 3 mid-frame changes nothing until the next frame_start.
5. Drop en at frame cycle 40 -> the frame completes all 120 cycles, running falls after the last position, and no further frame_start occurs. Dropping en then raising it again before the boundary produces no gap between frames.
6. Default parameters, HS_POL = VS_POL = 1 -> line period 1056 and frame 505 lines; hsync high for 128 clocks; 384000 de cycles per frame.
